// File: rtl/line_pixel_writer.sv
// Clips Bresenham pixels to the screen, converts them to framebuffer addresses and issues
// stallable writes through a small FIFO. Define CLIP_STATS_EN to add drawn/clipped counters.
module line_pixel_writer #(
   parameter int H_RES   = 64,
   parameter int V_RES   = 64,
   parameter int ADDR_W  = 12,
   parameter int COLOR_W = 8,
   parameter int DEPTH   = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                line_start,
   input  logic [COLOR_W-1:0]  line_color,
   input  logic                pix_valid,
   input  logic signed [31:0]  pix_x,
   input  logic signed [31:0]  pix_y,
   output logic                pix_ready,
   input  logic                line_end,
   output logic                fb_we,
   output logic [ADDR_W-1:0]   fb_addr,
   output logic [COLOR_W-1:0]  fb_data,
   input  logic                fb_ack,
   output logic                busy,
`ifdef CLIP_STATS_EN
   output logic [15:0]         drawn_cnt,
   output logic [15:0]         clipped_cnt,
`endif
   output logic                done
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [PTR_W:0]      count;
   logic [COLOR_W-1:0]  color;
   logic [ADDR_W-1:0]   last_addr;
   logic [ADDR_W-1:0]   lin_addr;
   logic                fifo_empty, fifo_full;
   logic                accept, in_bounds, push, pop;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (PTR_W+1)'(DEPTH));
   assign pix_ready  = (state == RUN) && !fifo_full;
   assign accept     = pix_valid && pix_ready;
   assign in_bounds  = (pix_x >= 0) && (pix_x < H_RES) && (pix_y >= 0) && (pix_y < V_RES);
   assign lin_addr   = ADDR_W'(pix_y * H_RES + pix_x);
   assign push       = accept && in_bounds;
   assign pop        = !fifo_empty && fb_ack;

   // Address holds its last written value once the FIFO runs dry.
   assign fb_we   = !fifo_empty;
   assign fb_addr = fb_we ? mem[rd_ptr] : last_addr;
   assign fb_data = color;
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= lin_addr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         color     <= '0;
         last_addr <= '0;
      end else begin
         case (state)
            IDLE: if (line_start) begin
               color <= line_color;
               state <= RUN;
            end
            RUN:   if (line_end) state <= DRAIN;
            DRAIN: if (fifo_empty) state <= DONE;
            DONE:  state <= IDLE;
            default: state <= IDLE;
         endcase
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            last_addr <= mem[rd_ptr];
         end
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

`ifdef CLIP_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drawn_cnt   <= '0;
         clipped_cnt <= '0;
      end else if (state == IDLE && line_start) begin
         drawn_cnt   <= '0;
         clipped_cnt <= '0;
      end else begin
         if (pop && drawn_cnt != '1) drawn_cnt <= drawn_cnt + 1'b1;
         if (accept && !in_bounds && clipped_cnt != '1) clipped_cnt <= clipped_cnt + 1'b1;
      end
   end
`endif

endmodule
